mem_stage: RTL



---
 rtl/mem_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: byte/half/word loads and stores over a req/ack bus
// Optional feature macro: MEM_ALIGN_CHECK_EN traps misaligned accesses instead of issuing them.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] maddr_i,
  input  logic [31:0] sdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        align_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state_q, state_d;

  logic        is_valid, is_store, load_q, misaligned, err_q;
  logic [3:0]  sel_d, op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_d, ldata_q, ext_d;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign is_valid = (memop_i >= OP_LB) && (memop_i <= OP_SW);
  assign is_store = (memop_i >= OP_SB) && (memop_i <= OP_SW);
  assign load_q   = (op_q >= OP_LB) && (op_q <= OP_LW);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (((memop_i == OP_LH) || (memop_i == OP_LHU) || (memop_i == OP_SH)) && maddr_i[0]) ||
                      (((memop_i == OP_LW) || (memop_i == OP_SW)) && (maddr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif
  assign align_err_o = err_q;

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    sel_d   = 4'b1111;
    wdata_d = sdata_i;
    case (memop_i)
      OP_LB, OP_LBU, OP_SB: sel_d = 4'b1000 >> maddr_i[1:0];
      OP_LH, OP_LHU, OP_SH: sel_d = maddr_i[1] ? 4'b0011 : 4'b1100;
      default: ;
    endcase
    if (memop_i == OP_SB) wdata_d = {4{sdata_i[7:0]}};
    if (memop_i == OP_SH) wdata_d = {2{sdata_i[15:0]}};
  end

  always_comb begin
    case (off_q)
      2'd0:    rbyte = bus_rdata_i[31:24];
      2'd1:    rbyte = bus_rdata_i[23:16];
      2'd2:    rbyte = bus_rdata_i[15:8];
      default: rbyte = bus_rdata_i[7:0];
    endcase
    rhalf = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (op_q)
      OP_LB:   ext_d = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  ext_d = {24'd0, rbyte};
      OP_LH:   ext_d = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  ext_d = {16'd0, rhalf};
      default: ext_d = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_sel_o   <= 4'd0;
      bus_wdata_o <= 32'd0;
      ldata_q     <= 32'd0;
      err_q       <= 1'b0;
      op_q        <= 4'd0;
      off_q       <= 2'd0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (is_valid) begin
          op_q  <= memop_i;
          off_q <= maddr_i[1:0];
          if (misaligned) begin
            err_q <= 1'b1;
          end else begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {maddr_i[31:2], 2'b00};
            bus_sel_o   <= sel_d;
            bus_wdata_o <= wdata_d;
          end
        end
        REQ: if (bus_ack_i) begin
          bus_req_o <= 1'b0;
          ldata_q   <= ext_d;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    stallreq_o = 1'b0;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    whilo_o    = whilo_i;
    hi_o       = hi_i;
    lo_o       = lo_i;
    case (state_q)
      IDLE: if (is_valid) begin
        stallreq_o = 1'b1;
        state_d    = misaligned ? DONE : REQ;
      end
      REQ: begin
        stallreq_o = 1'b1;
        if (bus_ack_i) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (load_q) wdata_o = ldata_q;
        if (err_q)  wreg_o  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Nothing leaks toward MEM/WB while reset is held.
    if (rst) begin
      stallreq_o = 1'b0;
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'd0;
      whilo_o    = 1'b0;
      hi_o       = 32'd0;
      lo_o       = 32'd0;
    end
  end

endmodule
